// File: rtl/and_unit_sched.sv
// Shares one LATENCY-cycle bitwise-AND pipeline among NREQ requesters, one issue per clock.
// Define AND_UNIT_SCHED_FIXED_PRIO_EN for lowest-index-wins arbitration instead of round-robin.
module and_unit_sched #(
    parameter int NREQ    = 4,
    parameter int W       = 8,
    parameter int LATENCY = 10
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] in1,
    input  logic [NREQ*W-1:0] in2,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   resp_valid,
    output logic [W-1:0]      out,
    output logic              busy
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // Tag is carried one-hot, so a zero tag doubles as the stage's valid bit.
    logic [NREQ-1:0] tag_q  [LATENCY];
    logic [NREQ-1:0] tag_d  [LATENCY];
    logic [W-1:0]    data_q [LATENCY];
    logic [W-1:0]    data_d [LATENCY];
    logic [NREQ-1:0] pending_q, pending_d;
    logic [NREQ-1:0] eligible;
    logic [W-1:0]    issue_data;
    logic            pipe_any;

`ifndef AND_UNIT_SCHED_FIXED_PRIO_EN
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   rr_idx;
    logic            rr_found;
`endif

    assign resp_valid = tag_q[LATENCY-1];
    assign out        = data_q[LATENCY-1];

    always_comb begin
        eligible = req & (~pending_q | resp_valid);
        gnt      = '0;
`ifdef AND_UNIT_SCHED_FIXED_PRIO_EN
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                gnt    = '0;
                gnt[i] = 1'b1;
            end
        end
`else
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            rr_idx = PW'((int'(ptr_q) + k) % NREQ);
            if (!rr_found && eligible[rr_idx]) begin
                gnt[rr_idx] = 1'b1;
                rr_found    = 1'b1;
            end
        end
`endif
        if (!reset_n) begin
            gnt = '0;
        end
    end

    always_comb begin
        issue_data = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                issue_data = in1[i*W +: W] & in2[i*W +: W];
            end
        end

`ifndef AND_UNIT_SCHED_FIXED_PRIO_EN
        ptr_d = ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                ptr_d = PW'(i);
            end
        end
`endif

        // A same-edge re-accept wins over the clear from the outgoing result.
        pending_d = (pending_q & ~resp_valid) | gnt;

        tag_d[0]  = gnt;
        data_d[0] = issue_data;
        for (int s = 1; s < LATENCY; s++) begin
            tag_d[s]  = tag_q[s-1];
            data_d[s] = data_q[s-1];
        end

        pipe_any = 1'b0;
        for (int s = 0; s < LATENCY; s++) begin
            pipe_any = pipe_any | (|tag_q[s]);
        end
        busy = pipe_any | (|pending_q);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pending_q <= '0;
            for (int s = 0; s < LATENCY; s++) begin
                tag_q[s]  <= '0;
                data_q[s] <= '0;
            end
`ifndef AND_UNIT_SCHED_FIXED_PRIO_EN
            ptr_q <= PW'(NREQ - 1);
`endif
        end else begin
            pending_q <= pending_d;
            for (int s = 0; s < LATENCY; s++) begin
                tag_q[s]  <= tag_d[s];
                data_q[s] <= data_d[s];
            end
`ifndef AND_UNIT_SCHED_FIXED_PRIO_EN
            ptr_q <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_and_unit_sched.sv
// Bench for and_unit_sched: a LATENCY=10 instance and a LATENCY=1 instance checked against a per-requester model.
// Honours AND_UNIT_SCHED_FIXED_PRIO_EN the same way as the design.
module tb_and_unit_sched;

    localparam int NR = 4;

    logic        clock;
    logic        reset_n;
    logic [3:0]  req_v  [2];
    logic [31:0] in1_v  [2];
    logic [31:0] in2_v  [2];
    logic [3:0]  gnt_w  [2];
    logic [3:0]  rv_w   [2];
    logic [7:0]  out_w  [2];
    logic        busy_w [2];

    int n_total = 0;
    int n_pass  = 0;

    and_unit_sched #(.NREQ(4), .W(8), .LATENCY(10)) u_dut_l10 (
        .clock(clock), .reset_n(reset_n), .req(req_v[0]), .in1(in1_v[0]), .in2(in2_v[0]),
        .gnt(gnt_w[0]), .resp_valid(rv_w[0]), .out(out_w[0]), .busy(busy_w[0])
    );

    and_unit_sched #(.NREQ(4), .W(8), .LATENCY(1)) u_dut_l1 (
        .clock(clock), .reset_n(reset_n), .req(req_v[1]), .in1(in1_v[1]), .in2(in2_v[1]),
        .gnt(gnt_w[1]), .resp_valid(rv_w[1]), .out(out_w[1]), .busy(busy_w[1])
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Model: per requester, whether an op is outstanding, the cycle its result shows, and its value.
    bit         m_pend [2][NR];
    int         m_show [2][NR];
    logic [7:0] m_dat  [2][NR];
    int         m_ptr  [2];
    int         ecnt = 0;
    bit         seen_rst = 1'b0;

    task automatic model_step(input int m);
        int         lat;
        logic [3:0] pvec, exp_rv, exp_gnt, elig;
        logic [7:0] exp_out;
        int         idx;
        bit         found;
        lat     = (m == 0) ? 10 : 1;
        exp_rv  = '0;
        exp_out = '0;
        pvec    = '0;
        for (int i = 0; i < NR; i++) begin
            pvec[i] = m_pend[m][i];
            if (m_pend[m][i] && m_show[m][i] == ecnt) begin
                exp_rv[i] = 1'b1;
                exp_out   = m_dat[m][i];
            end
        end
        elig    = req_v[m] & (~pvec | exp_rv);
        exp_gnt = '0;
        found   = 1'b0;
        if (reset_n) begin
`ifdef AND_UNIT_SCHED_FIXED_PRIO_EN
            for (int k = 0; k < NR; k++) begin
                if (!found && elig[k]) begin
                    exp_gnt[k] = 1'b1;
                    found = 1'b1;
                end
            end
`else
            for (int k = 1; k <= NR; k++) begin
                idx = (m_ptr[m] + k) % NR;
                if (!found && elig[idx]) begin
                    exp_gnt[idx] = 1'b1;
                    found = 1'b1;
                end
            end
`endif
        end
        if (seen_rst) begin
            chk($sformatf("m%0d gnt", m), 32'(gnt_w[m]), 32'(exp_gnt));
            chk($sformatf("m%0d resp_valid", m), 32'(rv_w[m]), 32'(exp_rv));
            chk($sformatf("m%0d out", m), 32'(out_w[m]), 32'(exp_out));
            chk($sformatf("m%0d busy", m), 32'(busy_w[m]), 32'(|pvec));
        end
        if (!reset_n) begin
            for (int i = 0; i < NR; i++) m_pend[m][i] = 1'b0;
            m_ptr[m] = NR - 1;
        end else begin
            for (int i = 0; i < NR; i++) begin
                if (exp_rv[i]) m_pend[m][i] = 1'b0;
                if (exp_gnt[i]) begin
                    m_pend[m][i] = 1'b1;
                    m_show[m][i] = ecnt + lat;
                    m_dat[m][i]  = in1_v[m][i*8 +: 8] & in2_v[m][i*8 +: 8];
                    m_ptr[m]     = i;
                end
            end
        end
    endtask

    always @(negedge clock) begin
        model_step(0);
        model_step(1);
        if (!reset_n) seen_rst = 1'b1;
        ecnt++;
    end

    task automatic do_reset();
        @(posedge clock); #2;
        reset_n = 1'b0;
        @(posedge clock); #2;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_total %0d", n_total);
        $fatal(1);
    end

    initial begin
        logic [7:0] e8;
        reset_n = 1'b0;
        for (int m = 0; m < 2; m++) begin
            req_v[m] = '0;
            in1_v[m] = '0;
            in2_v[m] = '0;
        end
        repeat (3) @(posedge clock);
        #2 reset_n = 1'b1;

        // Single op from requester 0: F0 & 3C = 30, ten cycles after acceptance.
        for (int j = 0; j <= 11; j++) begin
            @(posedge clock); #2;
            req_v[0] = (j == 0) ? 4'b0001 : 4'b0000;
            if (j == 0) begin
                in1_v[0][7:0] = 8'hF0;
                in2_v[0][7:0] = 8'h3C;
            end
            @(negedge clock);
            if (j == 0) chk("t1 gnt", 32'(gnt_w[0]), 32'h1);
            if (j >= 1) begin
                chk("t1 resp_valid", 32'(rv_w[0]), (j == 10) ? 32'h1 : 32'h0);
                chk("t1 busy", 32'(busy_w[0]), (j <= 10) ? 32'h1 : 32'h0);
            end
            if (j == 10) chk("t1 out", 32'(out_w[0]), 32'h30);
        end

        // All four held: grants 0..3, then re-grant of each in its own result cycle.
        do_reset();
        in1_v[0] = 32'hFFFF_FFFF;
        in2_v[0] = 32'h4433_2211;
        for (int k = 0; k <= 25; k++) begin
            @(posedge clock); #2;
            req_v[0] = (k < 14) ? 4'hF : 4'h0;
            @(negedge clock);
            if (k <= 3) chk("t2 first grants", 32'(gnt_w[0]), 32'(1 << k));
            if (k >= 4 && k <= 9) chk("t2 hold-off", 32'(gnt_w[0]), 32'h0);
            if (k >= 10 && k <= 13) begin
                e8 = 8'h11 * 8'(k - 9);
                chk("t2 regrant", 32'(gnt_w[0]), 32'(1 << (k - 10)));
                chk("t2 resp_valid", 32'(rv_w[0]), 32'(1 << (k - 10)));
                chk("t2 out", 32'(out_w[0]), 32'(e8));
            end
        end

        // Requester 2 re-requests while pending; requester 1 gets in meanwhile.
        in2_v[0][23:16] = 8'h5A;
        for (int k = 0; k <= 25; k++) begin
            @(posedge clock); #2;
            req_v[0] = {1'b0, (k <= 10), (k == 2), 1'b0};
            @(negedge clock);
            if (k == 0) chk("t3 gnt2", 32'(gnt_w[0]), 32'h4);
            if (k == 2) chk("t3 gnt1", 32'(gnt_w[0]), 32'h2);
            if (k == 1 || (k >= 3 && k <= 9)) chk("t3 held off", 32'(gnt_w[0]), 32'h0);
            if (k == 10) begin
                chk("t3 regrant2", 32'(gnt_w[0]), 32'h4);
                chk("t3 resp2", 32'(rv_w[0]), 32'h4);
                chk("t3 out2", 32'(out_w[0]), 32'h5A);
            end
            if (k == 12) chk("t3 out1", 32'(out_w[0]), 32'h22);
        end

        // Reset five cycles after acceptance discards the op.
        in1_v[0][7:0] = 8'h0F;
        for (int j = 0; j <= 20; j++) begin
            @(posedge clock); #2;
            req_v[0][0] = (j == 0);
            req_v[0][1] = (j == 5 || j == 6);
            reset_n     = (j != 5);
            @(negedge clock);
            if (j == 0) chk("t4 gnt", 32'(gnt_w[0]), 32'h1);
            if (j == 5) chk("t4 gnt in reset", 32'(gnt_w[0]), 32'h0);
            if (j == 6) begin
                chk("t4 busy after reset", 32'(busy_w[0]), 32'h0);
                chk("t4 out after reset", 32'(out_w[0]), 32'h0);
                chk("t4 gnt after reset", 32'(gnt_w[0]), 32'h2);
            end
            if (j >= 6 && j != 16) chk("t4 no stale resp", 32'(rv_w[0]), 32'h0);
            if (j == 16) chk("t4 resp1", 32'(rv_w[0]), 32'h2);
        end

        // Operand change after acceptance does not affect the result.
        for (int j = 0; j <= 11; j++) begin
            @(posedge clock); #2;
            req_v[0][0] = (j == 0);
            in1_v[0][7:0] = (j == 0) ? 8'hFF : 8'h00;
            in2_v[0][7:0] = 8'h81;
            @(negedge clock);
            if (j == 0) chk("t6 gnt", 32'(gnt_w[0]), 32'h1);
            if (j == 10) begin
                chk("t6 resp", 32'(rv_w[0]), 32'h1);
                chk("t6 out", 32'(out_w[0]), 32'h81);
            end
        end

        // Requesters 0 and 1 together with the pointer at 0.
        for (int j = 0; j <= 25; j++) begin
            @(posedge clock); #2;
            req_v[0][1:0] = (j <= 12) ? 2'b11 : 2'b00;
            @(negedge clock);
`ifdef AND_UNIT_SCHED_FIXED_PRIO_EN
            if (j == 0) chk("t7 fixed prio", 32'(gnt_w[0]), 32'h1);
`else
            if (j == 0) chk("t7 round robin", 32'(gnt_w[0]), 32'h2);
`endif
        end

        // LATENCY=1 instance: result next cycle, back-to-back regrants.
        in1_v[1][31:24] = 8'hAA;
        in2_v[1][31:24] = 8'h0F;
        for (int j = 0; j <= 8; j++) begin
            @(posedge clock); #2;
            req_v[1][3] = (j <= 5);
            @(negedge clock);
            if (j <= 5) chk("t5 gnt", 32'(gnt_w[1]), 32'h8);
            if (j >= 1 && j <= 6) begin
                chk("t5 resp", 32'(rv_w[1]), 32'h8);
                chk("t5 out", 32'(out_w[1]), 32'h0A);
            end
            if (j == 7) chk("t5 idle", 32'(rv_w[1]), 32'h0);
        end

        repeat (2) @(negedge clock);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
